// File: rtl/hc595_pkg.sv
// Shared types and defaults for the 74HC595 chain driver.
package hc595_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } hc595_state_e;

    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_CLK_DIV     = 4;
    localparam bit          DEF_MSB_FIRST   = 1'b1;
    localparam int unsigned DEF_REFRESH_CYC = 1000000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hc595_tick_gen.sv
// Half-period prescaler: tick_o pulses every CLK_DIV enabled cycles, restarts on clr_i.
module hc595_tick_gen
    import hc595_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned       PH_W    = cnt_w(CLK_DIV);
    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(CLK_DIV - 1);

    logic [PH_W-1:0] ph_q, ph_d;

    // NOTE: ph_d gets a default before any branch so this block can never infer a latch.
    always_comb begin
        ph_d = ph_q;
        if (clr_i) begin
            ph_d = '0;
        end else if (en_i) begin
            ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_d;
        end
    end

    assign tick_o = en_i && (ph_q == PH_LAST);

endmodule

// File: rtl/hc595_chain_drv.sv
// Serial driver for a chain of 74HC595s: shifts a DATA_W word out on DS/SH_CP, then pulses ST_CP.
// Define HC595_REFRESH_EN to re-send the last accepted word after REFRESH_CYC idle cycles.
module hc595_chain_drv
    import hc595_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
    parameter bit          MSB_FIRST   = DEF_MSB_FIRST,
    parameter int unsigned REFRESH_CYC = DEF_REFRESH_CYC
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] In_data,
    input  logic              In_valid,
    output logic              In_ready,
    output logic              Busy,
    output logic              SH_CP,
    output logic              ST_CP,
    output logic              DS
);

    if (DATA_W == 0 || CLK_DIV == 0 || REFRESH_CYC == 0) begin : g_param_err
        $error("hc595_chain_drv: DATA_W, CLK_DIV and REFRESH_CYC must be >= 1");
    end

    localparam int unsigned      BIT_W    = cnt_w(DATA_W + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    hc595_state_e      state_q;
    logic [DATA_W-1:0] sr_q, sr_d, load_word;
    logic [BIT_W-1:0]  bit_q;
    logic              sh_cp_q, st_cp_q, ds_q;
    logic              accept, refresh, start, tick;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    assign In_ready = (state_q == IDLE) && !Rst;
    assign accept   = In_valid && In_ready;
    assign start    = accept || refresh;

`ifdef HC595_REFRESH_EN
    localparam int unsigned       IDLE_W    = cnt_w(REFRESH_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(REFRESH_CYC - 1);

    logic [DATA_W-1:0] hold_q;
    logic              has_data_q;
    logic [IDLE_W-1:0] idle_cnt_q;

    // NOTE: hold_q carries no reset; has_data_q keeps it from being used before the first accept.
    always_ff @(posedge Clk) begin
        if (accept) begin
            hold_q <= In_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            has_data_q <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            if (accept) begin
                has_data_q <= 1'b1;
            end
            if (start) begin
                idle_cnt_q <= '0;
            end else if (state_q == IDLE && has_data_q) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
        end
    end

    assign refresh   = (state_q == IDLE) && has_data_q && (idle_cnt_q == IDLE_LAST);
    assign load_word = accept ? In_data : hold_q;
`else
    assign refresh   = 1'b0;
    assign load_word = In_data;
`endif

    always_comb begin
        sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
    end

    hc595_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .en_i   (state_q != IDLE),
        .clr_i  (start),
        .tick_o (tick)
    );

    // A SHIFT tick with SH_CP low raises it; a tick with SH_CP high ends the bit.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            sh_cp_q <= 1'b0;
            st_cp_q <= 1'b0;
            ds_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SHIFT;
                        sr_q    <= load_word;
                        bit_q   <= '0;
                        ds_q    <= first_bit(load_word);
                        sh_cp_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sh_cp_q) begin
                            sh_cp_q <= 1'b1;
                        end else begin
                            sh_cp_q <= 1'b0;
                            if (bit_q == BIT_LAST) begin
                                state_q <= LATCH;
                                ds_q    <= 1'b0;
                                st_cp_q <= 1'b1;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                                sr_q  <= sr_d;
                                ds_q  <= first_bit(sr_d);
                            end
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        st_cp_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy  = (state_q != IDLE);
    assign SH_CP = sh_cp_q;
    assign ST_CP = st_cp_q;
    assign DS    = ds_q;

endmodule
